// File: rtl/mem_spi_pkg.sv
// rtl/mem_spi_pkg.sv - shared SPI flash opcodes, status bit and state encodings
package mem_spi_pkg;

  localparam logic [7:0] SPI_OP_WREN = 8'h06;
  localparam logic [7:0] SPI_OP_PP   = 8'h02;
  localparam logic [7:0] SPI_OP_RDSR = 8'h05;
  localparam logic [7:0] SPI_OP_READ = 8'h03;

  localparam int STATUS_WIP_BIT = 0;

  localparam logic [6:0] BITS_WREN = 7'd8;
  localparam logic [6:0] BITS_PROG = 7'd64;
  localparam logic [6:0] BITS_POLL = 7'd16;

  typedef enum logic [1:0] {
    CG_IDLE,
    CG_ACTIVE,
    CG_TAIL
  } clk_gen_state_e;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_WREN,
    WR_PROG,
    WR_POLL,
    WR_DONE,
    WR_ERROR
  } wr_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - chip-select framing and divided SPI mode-0 clock
module spi_clk_gen
  import mem_spi_pkg::*;
#(
  parameter int CLK_DIV_LOG2 = 2,
  parameter int CS_SETUP     = 5,
  parameter int CS_HOLD      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  clk_gen_state_e mode,
  output logic           sclk,
  output logic           cs,
  output logic           rise,
  output logic           fall,
  output logic           tail_done
);

  localparam int CW   = 16;
  localparam int HALF = 2 ** (CLK_DIV_LOG2 - 1);

  clk_gen_state_e          mode_q;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           n;
  logic [CLK_DIV_LOG2-1:0] ph;

  // n = cycles spent in the current mode, 0 on the first cycle after a mode change
  assign n  = (mode != mode_q) ? '0 : cnt;
  assign ph = n[CLK_DIV_LOG2-1:0] - CS_SETUP[CLK_DIV_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= CG_IDLE;
      cnt    <= '0;
    end else begin
      mode_q <= mode;
      cnt    <= (n == '1) ? n : n + 1'b1;
    end
  end

  always_comb begin
    cs        = 1'b1;
    sclk      = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    tail_done = 1'b0;
    case (mode)
      CG_ACTIVE: begin
        cs = 1'b0;
        if (n >= CW'(CS_SETUP)) begin
          sclk = ~ph[CLK_DIV_LOG2-1];
          rise = (ph == '0);
          fall = (ph == HALF[CLK_DIV_LOG2-1:0]);
        end
      end
      CG_TAIL: begin
        // TAIL starts one cycle after the last falling edge, hence the -1 on both marks
        cs        = (n >= CW'(CS_HOLD - 1));
        tail_done = (n == CW'(2 * CS_HOLD - 2));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_write.sv
// rtl/mem_write.sv - SPI flash word writer: WREN, PAGE PROGRAM, then RDSR polling until WIP clears
module mem_write
  import mem_spi_pkg::*;
#(
  parameter int CLK_DIV_LOG2 = 2,
  parameter int CS_SETUP     = 5,
  parameter int CS_HOLD      = 8,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs,
  input  logic [23:0] target_address,
  input  logic [31:0] write_data,
  input  logic        start_write,
  output logic        write_done,
  output logic        write_error
);

  localparam int PCW = $clog2(POLL_LIMIT) + 1;

  wr_state_e      state;
  wr_state_e      state_nxt;
  clk_gen_state_e cg_mode;
  logic           in_tail;
  logic           frame_active;
  logic           frame_end;
  logic           sclk_rise;
  logic           sclk_fall;
  logic           tail_done;
  logic           poll_more;
  logic           unused_status;
  logic [63:0]    tx;
  logic [7:0]     rx;
  logic [6:0]     bits_left;
  logic [PCW-1:0] poll_count;
  logic [23:0]    addr_q;
  logic [31:0]    data_q;

  assign frame_active  = (state == WR_WREN) || (state == WR_PROG) || (state == WR_POLL);
  assign cg_mode       = !frame_active ? CG_IDLE : (in_tail ? CG_TAIL : CG_ACTIVE);
  assign frame_end     = frame_active && in_tail && tail_done;
  assign poll_more     = (int'(poll_count) + 1) < POLL_LIMIT;
  assign unused_status = ^rx;

  spi_clk_gen #(
    .CLK_DIV_LOG2(CLK_DIV_LOG2),
    .CS_SETUP    (CS_SETUP),
    .CS_HOLD     (CS_HOLD)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (cg_mode),
    .sclk     (sclk),
    .cs       (cs),
    .rise     (sclk_rise),
    .fall     (sclk_fall),
    .tail_done(tail_done)
  );

  assign mosi        = !cs ? tx[63] : 1'b0;
  assign write_done  = start_write && (state == WR_DONE);
  assign write_error = start_write && (state == WR_ERROR);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WR_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!start_write) begin
      state_nxt = WR_IDLE;
    end else begin
      case (state)
        WR_IDLE: state_nxt = WR_WREN;
        WR_WREN: if (frame_end) state_nxt = WR_PROG;
        WR_PROG: if (frame_end) state_nxt = WR_POLL;
        WR_POLL: begin
          if (frame_end) begin
            if (!rx[STATUS_WIP_BIT]) state_nxt = WR_DONE;
            else if (!poll_more)     state_nxt = WR_ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  // Each frame end preloads the next frame's shift register; a repeated POLL reuses RDSR
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx         <= '0;
      rx         <= '0;
      bits_left  <= '0;
      poll_count <= '0;
      in_tail    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (state == WR_IDLE) begin
      in_tail <= 1'b0;
      if (start_write) begin
        addr_q    <= target_address;
        data_q    <= write_data;
        tx        <= {SPI_OP_WREN, 56'd0};
        bits_left <= BITS_WREN;
      end
    end else if (frame_end) begin
      in_tail   <= 1'b0;
      bits_left <= (state == WR_WREN) ? BITS_PROG : BITS_POLL;
      if (state == WR_WREN) tx <= {SPI_OP_PP, addr_q, data_q};
      else                  tx <= {SPI_OP_RDSR, 56'd0};
      if (state == WR_PROG)
        poll_count <= '0;
      else if (state == WR_POLL && poll_count != '1)
        poll_count <= poll_count + 1'b1;
    end else if (frame_active && !in_tail) begin
      if (sclk_rise) rx <= {rx[6:0], miso};
      if (sclk_fall) begin
        tx        <= {tx[62:0], 1'b0};
        bits_left <= bits_left - 7'd1;
        if (bits_left == 7'd1) in_tail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_write.sv
// tb/tb_mem_write.sv - directed bench for mem_write against a cycle-sampled SPI flash model
module tb_mem_write;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miso = 1'b0;
  logic        start_write = 1'b0;
  logic [23:0] target_address = '0;
  logic [31:0] write_data = '0;
  logic        sclk, mosi, cs, write_done, write_error;

  mem_write #(.POLL_LIMIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miso          (miso),
    .sclk          (sclk),
    .mosi          (mosi),
    .cs            (cs),
    .target_address(target_address),
    .write_data    (write_data),
    .start_write   (start_write),
    .write_done    (write_done),
    .write_error   (write_error)
  );

  always #5 clk = ~clk;

  // Flash model: samples the bus once per clk and reacts to sclk/cs transitions.
  logic [7:0] mem [int];
  logic [7:0] cur [$];
  logic [7:0] log_bytes [$];
  logic [7:0] sh = '0;
  logic [7:0] status_now = '0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0, wel = 1'b0;
  int cyc = 0, rises = 0, falls = 0, frames = 0, rdsr_frames = 0, done_seen = 0;
  int busy_left = 0, busy_cfg = 0;
  int t_csfall = 0, t_csrise = -1, t_fall = 0, setup_meas = 0, hold_meas = 0, last_gap = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (write_done === 1'b1) done_seen = done_seen + 1;
    if (prev_cs === 1'b1 && cs === 1'b0) begin
      t_csfall = cyc;
      if (t_csrise >= 0) last_gap = cyc - t_csrise;
      rises = 0;
      falls = 0;
      cur.delete();
      status_now = {7'b0, busy_left > 0};
    end
    if (cs === 1'b0) begin
      if (prev_sclk === 1'b0 && sclk === 1'b1) begin
        if (rises == 0) setup_meas = cyc - t_csfall;
        sh = {sh[6:0], mosi};
        rises = rises + 1;
        if (rises % 8 == 0) cur.push_back(sh);
      end
      if (prev_sclk === 1'b1 && sclk === 1'b0) begin
        falls = falls + 1;
        t_fall = cyc;
        if (cur.size() > 0 && cur[0] == 8'h05 && rises >= 8 && rises < 16)
          miso <= status_now[15 - rises];
        else
          miso <= 1'b0;
      end
    end
    if (prev_cs === 1'b0 && cs === 1'b1) begin
      t_csrise = cyc;
      hold_meas = cyc - t_fall;
      frames = frames + 1;
      foreach (cur[k]) log_bytes.push_back(cur[k]);
      if (cur.size() > 0) begin
        if (cur[0] == 8'h06 && rises == 8) wel = 1'b1;
        if (cur[0] == 8'h02 && rises == 64 && wel) begin
          for (int k = 0; k < 4; k++)
            mem[int'({cur[1], cur[2], cur[3]}) + k] = cur[4 + k];
          busy_left = busy_cfg;
          wel = 1'b0;
        end
        if (cur[0] == 8'h05) begin
          rdsr_frames = rdsr_frames + 1;
          if (busy_left > 0) busy_left = busy_left - 1;
        end
      end
      miso <= 1'b0;
    end
    prev_cs = cs;
    prev_sclk = sclk;
  end

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
    int          busy;
    logic        exp_done;
    logic        exp_err;
    int          exp_polls;
  } vec_t;

  vec_t vecs [6];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_prog(input int n);
    return cs === 1'b0 && cur.size() > 0 && cur[0] == 8'h02 && falls >= n;
  endfunction

  initial begin
    logic [7:0] expb [$];
    logic [31:0] got_word;
    int bb, fb, rb, d0, lowcnt, a;
    bit hit;

    vecs[0] = '{24'h000100, 32'hDEADBEEF, 3,    1'b1, 1'b0, 4};
    vecs[1] = '{24'h00ABCD, 32'h12345678, 0,    1'b1, 1'b0, 1};
    vecs[2] = '{24'hFFFFF8, 32'hA5C30F81, 1,    1'b1, 1'b0, 2};
    vecs[3] = '{24'h123456, 32'h00000000, 4,    1'b0, 1'b1, 4};
    vecs[4] = '{24'h7F0010, 32'hFFFFFFFF, 1000, 1'b0, 1'b1, 4};
    vecs[5] = '{24'h000000, 32'h80000001, 2,    1'b1, 1'b0, 3};

    repeat (3) tick();
    check("reset_cs", cs, 1);
    check("reset_sclk", sclk, 0);
    check("reset_mosi", mosi, 0);
    check("reset_done", write_done, 0);
    check("reset_error", write_error, 0);
    rst_n = 1'b1;
    tick();

    // reset asserted in the middle of PAGE PROGRAM
    target_address = 24'h0000F0;
    write_data = 32'h01020304;
    start_write = 1'b1;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick();
      if (in_prog(10)) hit = 1;
    end
    check("rstprog_reached", hit, 1);
    rst_n = 1'b0;
    tick();
    check("rstprog_cs", cs, 1);
    check("rstprog_sclk", sclk, 0);
    check("rstprog_mosi", mosi, 0);
    check("rstprog_done", write_done, 0);
    check("rstprog_error", write_error, 0);
    start_write = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    // abort after 20 PROG falling edges
    d0 = done_seen;
    start_write = 1'b1;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick();
      if (in_prog(20)) hit = 1;
    end
    check("abort_reached", hit, 1);
    start_write = 1'b0;
    tick();
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 0);
    repeat (20) tick();
    check("abort_cs_idle", cs, 1);
    check("abort_done_never", done_seen - d0, 0);

    for (int v = 0; v < 6; v++) begin
      busy_cfg = vecs[v].busy;
      bb = log_bytes.size();
      fb = frames;
      rb = rdsr_frames;
      target_address = vecs[v].addr;
      write_data = vecs[v].data;
      start_write = 1'b1;
      tick();
      target_address = ~vecs[v].addr;
      write_data = ~vecs[v].data;
      hit = 0;
      for (int i = 0; i < 4000 && !hit; i++) begin
        tick();
        if (write_done === 1'b1 || write_error === 1'b1) hit = 1;
      end
      check($sformatf("v%0d_done", v), write_done, vecs[v].exp_done);
      check($sformatf("v%0d_error", v), write_error, vecs[v].exp_err);
      check($sformatf("v%0d_frames", v), frames - fb, 2 + vecs[v].exp_polls);
      check($sformatf("v%0d_rdsr", v), rdsr_frames - rb, vecs[v].exp_polls);

      expb.delete();
      expb.push_back(8'h06);
      expb.push_back(8'h02);
      expb.push_back(vecs[v].addr[23:16]);
      expb.push_back(vecs[v].addr[15:8]);
      expb.push_back(vecs[v].addr[7:0]);
      expb.push_back(vecs[v].data[31:24]);
      expb.push_back(vecs[v].data[23:16]);
      expb.push_back(vecs[v].data[15:8]);
      expb.push_back(vecs[v].data[7:0]);
      for (int p = 0; p < vecs[v].exp_polls; p++) begin
        expb.push_back(8'h05);
        expb.push_back(8'h00);
      end
      check($sformatf("v%0d_nbytes", v), log_bytes.size() - bb, expb.size());
      for (int k = 0; k < expb.size() && bb + k < log_bytes.size(); k++)
        check($sformatf("v%0d_byte%0d", v, k), log_bytes[bb + k], expb[k]);

      a = int'(vecs[v].addr);
      got_word = '0;
      if (mem.exists(a) && mem.exists(a + 3))
        got_word = {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
      check($sformatf("v%0d_readback", v), got_word, vecs[v].data);
      check($sformatf("v%0d_cs_setup", v), setup_meas, 5);
      check($sformatf("v%0d_cs_hold", v), hold_meas, 8);
      check($sformatf("v%0d_cs_gap", v), last_gap, 8);

      fb = frames;
      lowcnt = 0;
      repeat (200) begin
        tick();
        if (cs !== 1'b1) lowcnt++;
      end
      check($sformatf("v%0d_held_cs_low", v), lowcnt, 0);
      check($sformatf("v%0d_held_frames", v), frames - fb, 0);
      check($sformatf("v%0d_held_done", v), write_done, vecs[v].exp_done);
      check($sformatf("v%0d_held_error", v), write_error, vecs[v].exp_err);
      start_write = 1'b0;
      tick();
      check($sformatf("v%0d_drop_done", v), write_done, 0);
      check($sformatf("v%0d_drop_error", v), write_error, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
